eth_rx_ingress: RTL

//  Parametrised 10G Ethernet RX ingress stage: takes MAC-side AXIS frames, stores them in a commit/rollback

---
 rtl/eth_rx_ingress.sv | 240 ++++++++++++++++++++++++
 1 files changed

// File: rtl/eth_rx_ingress.sv
// rtl/eth_rx_ingress.sv - 10G RX ingress: commit/rollback frame buffer, per-frame port lookup, tagged AXIS replay
// Frames are written speculatively and only become visible to egress once their last beat proves them good.

module eth_rx_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 32
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr, rd;

  assign empty = (wr == rd);
  assign full  = (wr[AW] != rd[AW]) && (wr[AW-1:0] == rd[AW-1:0]);
  assign dout  = mem[rd[AW-1:0]];

  always_ff @(posedge i_clk)
    if (push) mem[wr[AW-1:0]] <= din;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr <= '0;
      rd <= '0;
    end else begin
      if (push) wr <= wr + PTR_ONE;
      if (pop)  rd <= rd + PTR_ONE;
    end
  end
endmodule

module eth_rx_ingress #(
  parameter logic [3:0] P_RX_PORT_ID = 4'd0,
  parameter int P_DATA_W     = 64,
  parameter int P_KEEP_W     = P_DATA_W / 8,
  parameter int P_BUF_DEPTH  = 512,
  parameter int P_DESC_DEPTH = 32,
  parameter int P_MAX_BEATS  = 190,
  parameter int P_MIN_BYTES  = 60
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_stat_rx_status,
  input  logic                s_axis_rx_tvalid,
  input  logic [P_DATA_W-1:0] s_axis_rx_tdata,
  input  logic                s_axis_rx_tlast,
  input  logic [P_KEEP_W-1:0] s_axis_rx_tkeep,
  input  logic                s_axis_rx_tuser,
  output logic [47:0]         o_check_mac,
  output logic [3:0]          o_check_id,
  output logic                o_check_valid,
  input  logic                i_result_valid,
  input  logic [2:0]          i_outport,
  input  logic [1:0]          i_seek_flag,
  output logic                m_axis_tvalid,
  output logic [P_DATA_W-1:0] m_axis_tdata,
  output logic                m_axis_tlast,
  output logic [P_KEEP_W-1:0] m_axis_tkeep,
  input  logic                m_axis_tready,
  output logic [1:0]          m_axis_tuser,
  output logic [2:0]          m_axis_tdest,
  output logic [31:0]         o_frame_cnt,
  output logic [31:0]         o_drop_cnt
);
  localparam int BA = $clog2(P_BUF_DEPTH);
  localparam int LW = $clog2(P_MAX_BEATS + 2);
  localparam int MW = P_KEEP_W + P_DATA_W;
  localparam logic [BA:0]   BUF_ONE   = 1;
  localparam logic [BA:0]   BUF_FULL  = P_BUF_DEPTH;
  localparam logic [LW-1:0] LEN_ONE   = 1;
  localparam logic [LW-1:0] LEN_MAX   = P_MAX_BEATS;
  localparam logic [LW-1:0] LEN_SAT   = P_MAX_BEATS + 1;
  localparam logic [15:0]   MIN_BYTES = P_MIN_BYTES;
  localparam logic [15:0]   KEEP_W16  = P_KEEP_W;
  localparam logic [31:0]   CNT_ONE   = 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SEND} state_t;

  function automatic logic [15:0] popcnt(input logic [P_KEEP_W-1:0] k);
    popcnt = '0;
    for (int i = 0; i < P_KEEP_W; i++) popcnt = popcnt + {15'd0, k[i]};
  endfunction

  logic [MW-1:0]   buf_mem [P_BUF_DEPTH];
  logic [BA:0]     wr_ptr, cm_ptr, rd_ptr;
  logic            in_frame, skip, bad;
  logic [LW-1:0]   beat_cnt, n;
  logic            accept, first, abort, buf_full, skip_cur, bad_cur, frame_drop, wr_en;
  logic [15:0]     bytes;
  logic [47:0]     mac_swap;
  logic            desc_push, desc_wr, desc_full, desc_empty, desc_pop, desc_drop;
  logic [LW:0]     desc_din, desc_dout;
  logic [LW-1:0]   desc_len;
  logic            res_wr, res_full, res_empty;
  logic [4:0]      res_dout;
  state_t          state;
  logic [LW-1:0]   remain;
  logic [MW-1:0]   rd_word;
  logic            in_drop, eg_drop, fwd_done;

  assign o_check_id = P_RX_PORT_ID;
  assign accept     = s_axis_rx_tvalid && i_stat_rx_status;
  assign first      = !in_frame;
  assign abort      = in_frame && !i_stat_rx_status;
  assign buf_full   = (wr_ptr - rd_ptr) == BUF_FULL;

  always_comb begin
    n          = first ? LEN_ONE : ((beat_cnt == LEN_SAT) ? LEN_SAT : beat_cnt + LEN_ONE);
    skip_cur   = first ? desc_full : skip;
    bad_cur    = (!first && bad) || (n > LEN_MAX) || buf_full;
    bytes      = 16'(n - LEN_ONE) * KEEP_W16 + popcnt(s_axis_rx_tkeep);
    frame_drop = bad_cur || s_axis_rx_tuser || (bytes < MIN_BYTES);
    mac_swap   = '0;
    for (int i = 0; i < 6; i++) mac_swap[47-8*i -: 8] = s_axis_rx_tdata[8*i +: 8];
  end

  assign wr_en     = accept && !skip_cur && !bad_cur;
  assign in_drop   = accept && first && desc_full;
  // An aborted frame already issued its lookup, so it still needs a descriptor to retire the result.
  assign desc_push = (accept && s_axis_rx_tlast && !skip_cur) || (abort && !skip);
  assign desc_din  = abort ? {{LW{1'b0}}, 1'b1} : {n, frame_drop};
  assign desc_wr   = desc_push && !desc_full;
  assign res_wr    = i_result_valid && !res_full;

  always_ff @(posedge i_clk)
    if (wr_en) buf_mem[wr_ptr[BA-1:0]] <= {s_axis_rx_tkeep, s_axis_rx_tdata};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr        <= '0;
      cm_ptr        <= '0;
      in_frame      <= 1'b0;
      skip          <= 1'b0;
      bad           <= 1'b0;
      beat_cnt      <= '0;
      o_check_valid <= 1'b0;
      o_check_mac   <= '0;
    end else begin
      o_check_valid <= accept && first && !desc_full;
      if (accept && first && !desc_full) o_check_mac <= mac_swap;
      if (abort) begin
        in_frame <= 1'b0;
        wr_ptr   <= cm_ptr;
        skip     <= 1'b0;
        bad      <= 1'b0;
      end else if (accept) begin
        if (s_axis_rx_tlast) begin
          in_frame <= 1'b0;
          skip     <= 1'b0;
          bad      <= 1'b0;
          if (!skip_cur && !frame_drop) begin
            wr_ptr <= wr_ptr + BUF_ONE;
            cm_ptr <= wr_ptr + BUF_ONE;
          end else begin
            wr_ptr <= cm_ptr;
          end
        end else begin
          in_frame <= 1'b1;
          beat_cnt <= n;
          skip     <= skip_cur;
          bad      <= bad_cur;
          if (wr_en) wr_ptr <= wr_ptr + BUF_ONE;
        end
      end
    end
  end

  eth_rx_fifo #(.W(LW + 1), .DEPTH(P_DESC_DEPTH)) u_desc_fifo (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .push(desc_wr), .din(desc_din),
    .pop(desc_pop), .dout(desc_dout), .empty(desc_empty), .full(desc_full)
  );

  eth_rx_fifo #(.W(5), .DEPTH(P_DESC_DEPTH)) u_res_fifo (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .push(res_wr), .din({i_outport, i_seek_flag}),
    .pop(desc_pop), .dout(res_dout), .empty(res_empty), .full(res_full)
  );

  assign {desc_len, desc_drop} = desc_dout;
  assign desc_pop = (state == S_LOAD);
  assign rd_word  = buf_mem[rd_ptr[BA-1:0]];
  assign eg_drop  = (state == S_LOAD) && desc_drop;
  assign fwd_done = (state == S_SEND) && m_axis_tready && m_axis_tlast;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state         <= S_IDLE;
      rd_ptr        <= '0;
      remain        <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
      m_axis_tkeep  <= '0;
      m_axis_tuser  <= '0;
      m_axis_tdest  <= '0;
      o_frame_cnt   <= '0;
      o_drop_cnt    <= '0;
    end else begin
      o_drop_cnt  <= o_drop_cnt + (in_drop ? CNT_ONE : '0) + (eg_drop ? CNT_ONE : '0);
      if (fwd_done) o_frame_cnt <= o_frame_cnt + CNT_ONE;
      case (state)
        S_IDLE: if (!desc_empty && !res_empty) state <= S_LOAD;
        S_LOAD: begin
          {m_axis_tdest, m_axis_tuser} <= res_dout;
          if (desc_drop) begin
            state <= S_IDLE;
          end else begin
            {m_axis_tkeep, m_axis_tdata} <= rd_word;
            m_axis_tvalid <= 1'b1;
            m_axis_tlast  <= (desc_len == LEN_ONE);
            remain        <= desc_len - LEN_ONE;
            rd_ptr        <= rd_ptr + BUF_ONE;
            state         <= S_SEND;
          end
        end
        S_SEND: if (m_axis_tready) begin
          if (m_axis_tlast) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            state         <= S_IDLE;
          end else begin
            {m_axis_tkeep, m_axis_tdata} <= rd_word;
            m_axis_tlast  <= (remain == LEN_ONE);
            remain        <= remain - LEN_ONE;
            rd_ptr        <= rd_ptr + BUF_ONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
